// File: rtl/serial_to_parallel_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : s2p_pkg
//  Purpose  : Shared definitions for the serial-to-parallel receiver:
//             FSM state encoding, default data width and the bit-count
//             width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package s2p_pkg;

  localparam int S2P_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } s2p_state_e;

  // Bits needed to hold a count from 0 up to and including width.
  function automatic int s2p_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_to_parallel_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_to_parallel_rx_if
//  Purpose  : Serial-in / word-out bundle for the serial_to_parallel_rx.
//  Ports    : s_in, s_valid, start        - serial side (master drives)
//             data_out, data_valid, busy,
//             frame_err                    - word side (slave drives)
//  Modports : master - traffic source / word sink
//             slave  - the receiver itself
//  Revision : 1.0 - initial release
// ============================================================================
interface serial_to_parallel_rx_if
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_DEFAULT_WIDTH
);
  logic             s_in;
  logic             s_valid;
  logic             start;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic             frame_err;

  modport master (
    output s_in, s_valid, start,
    input  data_out, data_valid, busy, frame_err
  );

  modport slave (
    input  s_in, s_valid, start,
    output data_out, data_valid, busy, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/serial_to_parallel_rx_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module   : rx_bit_counter
//  Purpose  : Data-bit counter for the receiver. Clears on clr (priority),
//             increments on en. tc flags that the next enabled increment
//             brings the count to WIDTH, i.e. the current bit completes the
//             word.
//  Ports    : clk, rst_n (async active-low), clr, en -> tc
//  Revision : 1.0 - initial release
// ============================================================================
module rx_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign tc = (r_count == C_LAST);
endmodule
`default_nettype wire

// File: rtl/serial_to_parallel_rx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_to_parallel_rx
//  Purpose  : Assembles a start-framed serial bit stream into a WIDTH-bit
//             word and presents it with a one-cycle data_valid strobe.
//             A start inside a frame aborts it (frame_err) and restarts.
//  Ports    : clk, rst_n (async active-low), bus (serial_to_parallel_rx_if
//             slave: s_in, s_valid, start -> data_out, data_valid, busy,
//             frame_err)
//  Options  : S2P_PARITY_EN - adds an even-parity bit after the data bits;
//             a mismatch drops the word and pulses frame_err.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_to_parallel_rx
  import s2p_pkg::*;
#(
  parameter int WIDTH     = S2P_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_to_parallel_rx_if.slave  bus
);
  localparam int CW = s2p_cnt_width(WIDTH);

  s2p_state_e       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_data_out;
  logic             r_data_valid;
  logic             r_busy;
  logic             r_frame_err;

  logic             w_shift_en;
  logic             w_last_bit;
  logic             w_cnt_clr;
  logic             w_tc;
  logic [WIDTH-1:0] w_shift_next;

  // start always wins over a coincident s_valid, so that bit is dropped.
  assign w_shift_en = (r_state == ST_SHIFT) && bus.s_valid && !bus.start;
  assign w_last_bit = w_shift_en && w_tc;

`ifdef S2P_PARITY_EN
  logic r_par;
  logic w_par_done;
  assign w_par_done = (r_state == ST_PAR) && bus.s_valid && !bus.start;
  assign w_cnt_clr  = bus.start | w_par_done;
`else
  assign w_cnt_clr  = bus.start | w_last_bit;
`endif

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift_next = {r_shift[WIDTH-2:0], bus.s_in};
    end else begin : g_lsb_first
      assign w_shift_next = {bus.s_in, r_shift[WIDTH-1:1]};
    end
  endgenerate

  rx_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_cnt_clr),
    .en    (w_shift_en),
    .tc    (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef S2P_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;

      if (w_shift_en) begin
        r_shift <= w_shift_next;
      end

`ifdef S2P_PARITY_EN
      // Running XOR of the data bits; restarts with every frame.
      if (bus.start) begin
        r_par <= 1'b0;
      end else if (w_shift_en) begin
        r_par <= r_par ^ bus.s_in;
      end
`endif

      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_SHIFT;
            r_busy  <= 1'b1;
          end
        end

        ST_SHIFT: begin
          if (bus.start) begin
            r_frame_err <= 1'b1;
          end else if (w_last_bit) begin
`ifdef S2P_PARITY_EN
            r_state <= ST_PAR;
`else
            r_data_out   <= w_shift_next;
            r_data_valid <= 1'b1;
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
`endif
          end
        end

`ifdef S2P_PARITY_EN
        ST_PAR: begin
          if (bus.start) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_SHIFT;
          end else if (bus.s_valid) begin
            if (r_par ^ bus.s_in) begin
              r_frame_err <= 1'b1;
            end else begin
              r_data_out   <= r_shift;
              r_data_valid <= 1'b1;
            end
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
`endif

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.busy       = r_busy;
  assign bus.frame_err  = r_frame_err;
endmodule
`default_nettype wire

// File: tb/tb_serial_to_parallel_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_to_parallel_rx
//  Purpose  : Self-checking bench for serial_to_parallel_rx. Two receivers
//             (MSB-first and LSB-first) share one serial stream. Honours
//             S2P_PARITY_EN the same way the design does.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_to_parallel_rx;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic s_in  = 1'b0;
  logic s_valid = 1'b0;
  logic start = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_valid_m = 0;
  int n_ferr_m  = 0;

  always #5 clk = ~clk;

  serial_to_parallel_rx_if #(.WIDTH(4)) if_m ();
  serial_to_parallel_rx_if #(.WIDTH(4)) if_l ();

  assign if_m.s_in = s_in;
  assign if_m.s_valid = s_valid;
  assign if_m.start = start;
  assign if_l.s_in = s_in;
  assign if_l.s_valid = s_valid;
  assign if_l.start = start;

  serial_to_parallel_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .bus(if_m.slave));
  serial_to_parallel_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .bus(if_l.slave));

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (if_m.data_valid === 1'b1) n_valid_m++;
    if (if_m.frame_err === 1'b1) n_ferr_m++;
  end

  typedef struct {
    logic [3:0] seq;     // seq[3] is sent first
    int         gap;     // idle cycles between data bits
    logic [3:0] exp_m;
    logic [3:0] exp_l;
  } vec_t;

  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the k-th received bit lands at WIDTH-1-k (MSB first) or k.
  function automatic logic [3:0] model(input logic [3:0] seq, input bit msb);
    logic [3:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      if (msb) w[3-k] = seq[3-k];
      else     w[k]   = seq[3-k];
    end
    return w;
  endfunction

  // Back-to-back data bits (plus a correct parity bit when enabled).
  task automatic send_bits(input logic [3:0] seq);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_in = seq[3-i]; tick();
    end
`ifdef S2P_PARITY_EN
    s_in = ^seq; tick();
`endif
    s_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [3:0] seq, input int gap, input bit flip,
                           input logic [3:0] em, input logic [3:0] el);
    logic [3:0] prev_m, prev_l;
    prev_m = if_m.data_out;
    prev_l = if_l.data_out;
    start = 1'b1; tick(); start = 1'b0;
    check("busy_after_start", if_m.busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_in = seq[3-i]; tick(); s_valid = 1'b0;
      if (i < 3) begin
        repeat (gap) tick();
        check("busy_mid_frame", if_m.busy, 1'b1);
        check("no_early_valid", if_m.data_valid, 1'b0);
      end
    end
`ifdef S2P_PARITY_EN
    check("par_wait_busy", if_m.busy, 1'b1);
    check("par_wait_novalid", if_m.data_valid, 1'b0);
    repeat (gap) tick();
    s_valid = 1'b1; s_in = (^seq) ^ flip; tick(); s_valid = 1'b0;
`else
    flip = 1'b0;
`endif
    if (flip) begin
      check("par_err_ferr", if_m.frame_err, 1'b1);
      check("par_err_novalid", if_m.data_valid, 1'b0);
      check("par_err_hold_m", if_m.data_out, prev_m);
      check("par_err_hold_l", if_l.data_out, prev_l);
    end else begin
      check("valid_m", if_m.data_valid, 1'b1);
      check("valid_l", if_l.data_valid, 1'b1);
      check("data_m", if_m.data_out, em);
      check("data_l", if_l.data_out, el);
      check("no_ferr", if_m.frame_err, 1'b0);
    end
    check("busy_done", if_m.busy, 1'b0);
    tick();
    check("valid_one_cycle", if_m.data_valid, 1'b0);
    check("ferr_one_cycle", if_m.frame_err, 1'b0);
  endtask

  initial begin
    int v0, f0, t1;
    logic [3:0] seq;
    bit flip;

    tbl[0] = '{4'b1011, 0, 4'b1011, 4'b1101};
    tbl[1] = '{4'b0110, 3, 4'b0110, 4'b0110};
    tbl[2] = '{4'b1000, 1, 4'b1000, 4'b0001};
    tbl[3] = '{4'b1110, 0, 4'b1110, 4'b0111};
    tbl[4] = '{4'b0000, 2, 4'b0000, 4'b0000};
    tbl[5] = '{4'b1111, 0, 4'b1111, 4'b1111};

    // Reset state
    repeat (2) tick();
    check("rst_data_m", if_m.data_out, 4'h0);
    check("rst_data_l", if_l.data_out, 4'h0);
    check("rst_valid", if_m.data_valid, 1'b0);
    check("rst_busy", if_m.busy, 1'b0);
    check("rst_ferr", if_m.frame_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // Table vectors
    for (int i = 0; i < 6; i++)
      run_frame(tbl[i].seq, tbl[i].gap, 1'b0, tbl[i].exp_m, tbl[i].exp_l);

    // IDLE ignores serial traffic
    v0 = n_valid_m;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_in = i[0]; tick();
    end
    s_valid = 1'b0; tick();
    check("idle_busy", if_m.busy, 1'b0);
    check("idle_hold", if_m.data_out, 4'b1111);
    check("idle_no_valid", n_valid_m - v0, 0);

    // Abort after two bits, then a full 1111 frame
    run_frame(4'b0101, 0, 1'b0, 4'b0101, 4'b1010);
    v0 = n_valid_m; f0 = n_ferr_m;
    start = 1'b1; tick(); start = 1'b0;
    s_valid = 1'b1; s_in = 1'b1; tick(); tick(); s_valid = 1'b0;
    start = 1'b1; s_valid = 1'b1; s_in = 1'b0; tick(); start = 1'b0; s_valid = 1'b0;
    check("abort_ferr", if_m.frame_err, 1'b1);
    check("abort_busy", if_m.busy, 1'b1);
    check("abort_hold", if_m.data_out, 4'b0101);
    send_bits(4'b1111);
    check("abort_new_data", if_m.data_out, 4'b1111);
    check("abort_new_valid", if_m.data_valid, 1'b1);
    check("abort_ferr_once", n_ferr_m - f0, 1);
    check("abort_no_valid", n_valid_m - v0, 0);
    tick();

    // Back-to-back frames with start in the data_valid cycle
    start = 1'b1; tick(); start = 1'b0;
    send_bits(4'b1010);
    check("b2b_valid1", if_m.data_valid, 1'b1);
    check("b2b_data1", if_m.data_out, 4'b1010);
    t1 = cyc;
    start = 1'b1; tick(); start = 1'b0;
    send_bits(4'b0101);
    check("b2b_valid2", if_m.data_valid, 1'b1);
    check("b2b_data2", if_m.data_out, 4'b0101);
`ifdef S2P_PARITY_EN
    check("b2b_spacing", cyc - t1, 6);
`else
    check("b2b_spacing", cyc - t1, 5);
`endif
    tick();

`ifdef S2P_PARITY_EN
    // Good parity then bad parity
    run_frame(4'b1011, 0, 1'b0, 4'b1011, 4'b1101);
    run_frame(4'b0011, 0, 1'b1, 4'b0011, 4'b1100);
    check("par_final_hold", if_m.data_out, 4'b1011);
`endif

    // Randomized frames against the reference model
    for (int i = 0; i < 30; i++) begin
      seq = 4'($urandom_range(0, 15));
`ifdef S2P_PARITY_EN
      flip = 1'($urandom_range(0, 1));
`else
      flip = 1'b0;
`endif
      run_frame(seq, $urandom_range(0, 3), flip, model(seq, 1'b1), model(seq, 1'b0));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset mid-frame
    run_frame(4'b1001, 0, 1'b0, 4'b1001, 4'b1001);
    v0 = n_valid_m;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_in = 1'b1; tick();
    end
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data", if_m.data_out, 4'h0);
    check("mid_rst_busy", if_m.busy, 1'b0);
    check("mid_rst_valid", if_m.data_valid, 1'b0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("mid_rst_no_strobe", n_valid_m - v0, 0);
    run_frame(4'b1011, 0, 1'b0, 4'b1011, 4'b1101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
